// File: rtl/register_bank_sb.sv
// Parametrised 2R/1W register bank with write-to-read bypass,
// optional hardwired zero register and a per-register pending scoreboard.
module register_bank_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1,
    parameter int CNT_W    = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] dest,
    input  logic [DATA_W-1:0] Din,
    input  logic [ADDR_W-1:0] srcadd1,
    input  logic [ADDR_W-1:0] srcadd2,
    output logic [DATA_W-1:0] src1,
    output logic [DATA_W-1:0] src2,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              src1_busy,
    output logic              src2_busy,
    output logic [CNT_W-1:0]  pending_cnt
);

    localparam int NREG = 2**ADDR_W;

    logic [DATA_W-1:0] r_mem [NREG];
    logic [NREG-1:0]   r_pend;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_wr;
    logic              w_rsv;
    logic              w_set;
    logic              w_clr;
    logic [NREG-1:0]   w_pend_nxt;
    logic [ADDR_W-1:0] w_sa  [2];
    logic [DATA_W-1:0] w_rd  [2];
    logic              w_bsy [2];

    assign w_wr  = wr_en  && !(ZERO_REG != 0 && dest == '0);
    assign w_rsv = rsv_en && !(ZERO_REG != 0 && rsv_addr == '0);

    // a reserve to the written register wins, so that bit never clears
    assign w_set = w_rsv && !r_pend[rsv_addr];
    assign w_clr = w_wr && r_pend[dest] && !(w_rsv && rsv_addr == dest);

    always_comb begin
        w_pend_nxt = r_pend;
        if (w_wr)
            w_pend_nxt[dest] = 1'b0;
        if (w_rsv)
            w_pend_nxt[rsv_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                r_mem[i] <= '0;
            r_pend <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_wr)
                r_mem[dest] <= Din;
            r_pend <= w_pend_nxt;
            r_cnt  <= r_cnt + CNT_W'(w_set) - CNT_W'(w_clr);
        end
    end

    assign w_sa[0] = srcadd1;
    assign w_sa[1] = srcadd2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rd[p]  = r_mem[w_sa[p]];
            w_bsy[p] = r_pend[w_sa[p]];
            if (BYPASS != 0 && wr_en && dest == w_sa[p]) begin
                w_rd[p]  = Din;
                w_bsy[p] = rsv_en && rsv_addr == w_sa[p];
            end
            if ((ZERO_REG != 0 && w_sa[p] == '0) || !rst_n) begin
                w_rd[p]  = '0;
                w_bsy[p] = 1'b0;
            end
        end
    end

    assign src1        = w_rd[0];
    assign src2        = w_rd[1];
    assign src1_busy   = w_bsy[0];
    assign src2_busy   = w_bsy[1];
    assign pending_cnt = r_cnt;

endmodule
